// File: rtl/mem_dma_pkg.sv
// Shared types and memory-map constants for the mem_dma block-copy engine.
package mem_dma_pkg;

  localparam int ADDR_W_DEF = 27;
  localparam int LEN_W_DEF  = 16;

  localparam logic [26:0] SDRAM_BASE  = 27'h000000;
  localparam logic [26:0] SPI_BASE    = 27'h800000;
  localparam logic [26:0] VRAM32_BASE = 27'hC00000;
  localparam logic [26:0] VRAM8_BASE  = 27'hC00420;
  localparam logic [26:0] ROM_BASE    = 27'hC02422;
  localparam logic [26:0] IO_BASE     = 27'hC02622;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/mem_txn.sv
// One memory-unit start/busy handshake: decodes busy-seen / access-done and
// bounds the access with a cycle counter that restarts for every access.
module mem_txn #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_ph,
  input  logic        wait_ph,
  input  logic        mem_busy,
  input  logic [31:0] mem_q,
  output logic        busy_seen,
  output logic        done,
  output logic        timeout,
  output logic [31:0] q
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic          active;
  logic [CW-1:0] cnt_q, cnt_d;

  assign active    = req_ph | wait_ph;
  assign busy_seen = req_ph & mem_busy;
  assign done      = wait_ph & ~mem_busy;
  assign q         = mem_q;
  // Completion on the final allowed cycle wins over the abort.
  assign timeout   = active & ~done & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!active || done) cnt_d = '0;
    else                 cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_dma.sv
// Word-by-word block copy master for the memory-unit CPU port.
// Define MEM_DMA_FILL_EN to enable pattern-fill jobs (cfg_fill_mode=1).
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int LEN_W          = LEN_W_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [31:0]       cfg_fill,
  input  logic              cfg_fill_mode,
  input  logic              go,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              dma_err,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data,
  output logic              mem_we,
  output logic              mem_start,
  input  logic              mem_busy,
  input  logic [31:0]       mem_q,
  input  logic              mem_init_done
);

`ifdef MEM_DMA_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  state_t            state_q;
  logic [ADDR_W-1:0] src_q, dst_q, addr_q;
  logic [LEN_W-1:0]  len_q, words_q;
  logic [31:0]       data_q;
  logic              fill_q, busy_q, done_q, err_q, we_q, start_q;

  logic        req_ph, wait_ph, busy_seen, txn_done, txn_timeout;
  logic [31:0] txn_q;

  assign req_ph  = (state_q == S_RD_REQ)  || (state_q == S_WR_REQ);
  assign wait_ph = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);

  mem_txn #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_txn (
    .clk       (clk),
    .reset     (reset),
    .req_ph    (req_ph),
    .wait_ph   (wait_ph),
    .mem_busy  (mem_busy),
    .mem_q     (mem_q),
    .busy_seen (busy_seen),
    .done      (txn_done),
    .timeout   (txn_timeout),
    .q         (txn_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (go && mem_init_done && !mem_busy) begin
            src_q   <= cfg_src;
            dst_q   <= cfg_dst;
            len_q   <= cfg_len;
            fill_q  <= FILL_EN && cfg_fill_mode;
            err_q   <= 1'b0;
            words_q <= '0;
            if (cfg_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (FILL_EN && cfg_fill_mode) begin
              state_q <= S_WR_REQ;
              busy_q  <= 1'b1;
              start_q <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= cfg_dst;
              data_q  <= cfg_fill;
            end else begin
              state_q <= S_RD_REQ;
              busy_q  <= 1'b1;
              start_q <= 1'b1;
              addr_q  <= cfg_src;
            end
          end
        end
        // start was dropped on the previous access's busy-low edge; re-raise here.
        S_RD_REQ, S_WR_REQ: begin
          start_q <= 1'b1;
          if (busy_seen)
            state_q <= (state_q == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
        end
        S_RD_WAIT: begin
          if (txn_done) begin
            start_q <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= dst_q;
            data_q  <= txn_q;
            state_q <= S_WR_REQ;
          end
        end
        S_WR_WAIT: begin
          if (txn_done) begin
            start_q <= 1'b0;
            words_q <= words_q + LEN_W'(1);
            src_q   <= src_q + ADDR_W'(1);
            dst_q   <= dst_q + ADDR_W'(1);
            len_q   <= len_q - LEN_W'(1);
            if (len_q == LEN_W'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              we_q    <= 1'b0;
              addr_q  <= '0;
              data_q  <= '0;
            end else if (fill_q) begin
              state_q <= S_WR_REQ;
              addr_q  <= dst_q + ADDR_W'(1);
            end else begin
              state_q <= S_RD_REQ;
              we_q    <= 1'b0;
              addr_q  <= src_q + ADDR_W'(1);
              data_q  <= '0;
            end
          end
        end
        S_DONE, S_ERR: state_q <= S_IDLE;
        default:       state_q <= S_IDLE;
      endcase

      if (txn_timeout) begin
        state_q <= S_ERR;
        start_q <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= '0;
        data_q  <= '0;
        busy_q  <= 1'b0;
        err_q   <= 1'b1;
        done_q  <= 1'b1;
      end
    end
  end

  assign dma_busy    = busy_q;
  assign dma_done    = done_q;
  assign dma_err     = err_q;
  assign words_done  = words_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_we      = we_q;
  assign mem_start   = start_q;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: negedge memory-unit model plus write scoreboard.
`timescale 1ns/1ps
module tb_mem_dma;
  localparam int AW = 27;
  localparam int LW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0, reset = 1'b0;
  logic [AW-1:0] cfg_src = '0, cfg_dst = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [31:0]   cfg_fill = '0;
  logic          cfg_fill_mode = 1'b0, go = 1'b0, mem_init_done = 1'b0;
  logic          dma_busy, dma_done, dma_err, mem_we, mem_start, mem_busy;
  logic [LW-1:0] words_done;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data, mem_q;

  always #5 clk = ~clk;

  mem_dma #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_fill(cfg_fill), .cfg_fill_mode(cfg_fill_mode), .go(go),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err), .words_done(words_done),
    .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we), .mem_start(mem_start),
    .mem_busy(mem_busy), .mem_q(mem_q), .mem_init_done(mem_init_done)
  );

  int checks = 0, failures = 0;

  // Memory-unit model: busy/q change on negedge; an access arms on a negedge with start high.
  logic [31:0]   mem [int];
  logic          busy_m = 1'b0, start_prev = 1'b0, a_we = 1'b0;
  logic [31:0]   q_m = '0, a_data = '0;
  logic [AW-1:0] a_addr = '0;
  int lat = 1, lat_cnt = 0, acc_cnt = 0, hang_at = -1, rd_cnt = 0, rises = 0, done_cnt = 0;
  bit hang = 1'b0;
  logic [AW-1:0] exp_a[$], act_a[$];
  logic [31:0]   exp_d[$], act_d[$];
  logic [AW-1:0] ea, aa;
  logic [31:0]   ed, ad;

  assign mem_busy = busy_m;
  assign mem_q    = q_m;

  always @(negedge clk) begin
    if (mem_start && !start_prev) rises++;
    start_prev = mem_start;
    if (dma_done) done_cnt++;
    if (busy_m) begin
      if (!hang) begin
        if (lat_cnt == 0) begin
          busy_m <= 1'b0;
          if (a_we) begin
            mem[int'(a_addr)] = a_data;
            act_a.push_back(a_addr);
            act_d.push_back(a_data);
          end else begin
            q_m <= mem.exists(int'(a_addr)) ? mem[int'(a_addr)] : 32'h0;
          end
        end else lat_cnt--;
      end
    end else if (mem_start) begin
      busy_m <= 1'b1;
      acc_cnt++;
      hang    = (acc_cnt == hang_at);
      lat_cnt = lat;
      a_addr  = mem_address;
      a_we    = mem_we;
      a_data  = mem_data;
      if (!mem_we) rd_cnt++;
    end
  end

  task automatic clr_stats();
    rises = 0; done_cnt = 0; rd_cnt = 0; acc_cnt = 0;
    exp_a.delete(); exp_d.delete(); act_a.delete(); act_d.delete();
  endtask

  task automatic pulse_go(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                          input logic [31:0] f, input logic fm);
    @(negedge clk);
    cfg_src = s; cfg_dst = d; cfg_len = n; cfg_fill = f; cfg_fill_mode = fm; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (dma_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({dma_busy, dma_done, dma_err, words_done, mem_address, mem_data, mem_we, mem_start} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b wd=%0d addr=%h data=%h we=%b start=%b want all 0",
               dma_busy, dma_done, dma_err, words_done, mem_address, mem_data, mem_we, mem_start);
    end
    @(negedge clk); reset = 1'b1; mem_init_done = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_copy();
    bit ok;
    clr_stats(); lat = 1;
    for (int n = 0; n < 4; n++) begin
      mem[32'h800000 + n] = 32'hA0 + n;
      exp_a.push_back(AW'(32'h10 + n)); exp_d.push_back(32'hA0 + n);
    end
    pulse_go(27'h800000, 27'h10, 16'd4, 32'h0, 1'b0);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL copy_done_timeout got none want dma_done"); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL copy_done_count got %0d want 1", done_cnt); end
    checks++; if (rises != 8) begin failures++; $display("FAIL copy_start_pulses got %0d want 8", rises); end
    checks++; if (rd_cnt != 4) begin failures++; $display("FAIL copy_reads got %0d want 4", rd_cnt); end
    checks++; if (words_done !== 16'd4) begin failures++; $display("FAIL copy_words_done got %0d want 4", words_done); end
    checks++; if (dma_err !== 1'b0) begin failures++; $display("FAIL copy_err got %b want 0", dma_err); end
    checks++; if ({dma_busy, mem_address} !== '0) begin failures++; $display("FAIL copy_idle got busy=%b addr=%h want 0/0", dma_busy, mem_address); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); ed = exp_d.pop_front(); checks++;
      if (act_a.size() == 0) begin failures++; $display("FAIL copy_write missing want %h<=%h", ea, ed); end
      else begin
        aa = act_a.pop_front(); ad = act_d.pop_front();
        if (aa !== ea || ad !== ed) begin failures++; $display("FAIL copy_write got %h<=%h want %h<=%h", aa, ad, ea, ed); end
      end
    end
    checks++; if (act_a.size() != 0) begin failures++; $display("FAIL copy_extra_writes got %0d want 0", act_a.size()); end
  endtask

  task automatic test_len0();
    clr_stats();
    pulse_go(27'h800000, 27'h50, 16'd0, 32'h0, 1'b0);
    checks++; if (dma_done !== 1'b1) begin failures++; $display("FAIL len0_done_next_cycle got %b want 1", dma_done); end
    repeat (5) @(negedge clk);
    checks++; if (rises != 0) begin failures++; $display("FAIL len0_start got %0d want 0", rises); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL len0_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    clr_stats(); lat = 1; hang_at = 3;
    exp_a.push_back(27'h100); exp_d.push_back(32'hA0);
    pulse_go(27'h800000, 27'h100, 16'd3, 32'h0, 1'b0);
    wait_done(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_no_done got none want dma_done"); end
    checks++; if (dma_err !== 1'b1) begin failures++; $display("FAIL timeout_err got %b want 1", dma_err); end
    checks++; if (words_done !== 16'd1) begin failures++; $display("FAIL timeout_words got %0d want 1", words_done); end
    checks++; if ({mem_start, mem_we} !== 2'b00) begin failures++; $display("FAIL timeout_start got %b%b want 00", mem_start, mem_we); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL timeout_done_count got %0d want 1", done_cnt); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); ed = exp_d.pop_front(); checks++;
      if (act_a.size() == 0) begin failures++; $display("FAIL timeout_write missing want %h<=%h", ea, ed); end
      else begin
        aa = act_a.pop_front(); ad = act_d.pop_front();
        if (aa !== ea || ad !== ed) begin failures++; $display("FAIL timeout_write got %h<=%h want %h<=%h", aa, ad, ea, ed); end
      end
    end
    checks++; if (act_a.size() != 0) begin failures++; $display("FAIL timeout_extra_writes got %0d want 0", act_a.size()); end
    hang_at = -1; hang = 1'b0;
    for (int i = 0; i < 10 && mem_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignore();
    bit ok;
    clr_stats(); lat = 1; mem_init_done = 1'b0;
    pulse_go(27'h800000, 27'h200, 16'd1, 32'h0, 1'b0);
    repeat (10) @(negedge clk);
    checks++; if (rises != 0 || done_cnt != 0) begin failures++; $display("FAIL ignore_noinit got starts=%0d dones=%0d want 0/0", rises, done_cnt); end
    mem_init_done = 1'b1;
    for (int n = 0; n < 2; n++) begin exp_a.push_back(AW'(32'h20 + n)); exp_d.push_back(32'hA0 + n); end
    pulse_go(27'h800000, 27'h20, 16'd2, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (dma_busy !== 1'b1) begin failures++; $display("FAIL ignore_busy_window got %b want 1", dma_busy); end
    pulse_go(27'h800002, 27'h40, 16'd1, 32'h0, 1'b0);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ignore_no_done got none want dma_done"); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL ignore_done_count got %0d want 1", done_cnt); end
    checks++; if (words_done !== 16'd2 || dma_err !== 1'b0) begin failures++; $display("FAIL ignore_status got wd=%0d err=%b want 2/0", words_done, dma_err); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); ed = exp_d.pop_front(); checks++;
      if (act_a.size() == 0) begin failures++; $display("FAIL ignore_write missing want %h<=%h", ea, ed); end
      else begin
        aa = act_a.pop_front(); ad = act_d.pop_front();
        if (aa !== ea || ad !== ed) begin failures++; $display("FAIL ignore_write got %h<=%h want %h<=%h", aa, ad, ea, ed); end
      end
    end
    checks++; if (act_a.size() != 0) begin failures++; $display("FAIL ignore_extra_writes got %0d want 0", act_a.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    clr_stats();
    exp_a.push_back(27'h7FFFFFF); exp_d.push_back(32'hA0);
    exp_a.push_back(27'h0);       exp_d.push_back(32'hA1);
    pulse_go(27'h800000, 27'h7FFFFFF, 16'd2, 32'h0, 1'b0);
    wait_done(200, ok);
    checks++; if (!ok || words_done !== 16'd2) begin failures++; $display("FAIL wrap_done got ok=%0d wd=%0d want 1/2", ok, words_done); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); ed = exp_d.pop_front(); checks++;
      if (act_a.size() == 0) begin failures++; $display("FAIL wrap_write missing want %h<=%h", ea, ed); end
      else begin
        aa = act_a.pop_front(); ad = act_d.pop_front();
        if (aa !== ea || ad !== ed) begin failures++; $display("FAIL wrap_write got %h<=%h want %h<=%h", aa, ad, ea, ed); end
      end
    end
  endtask

  task automatic test_fill();
    bit ok;
    int exp_rd;
    clr_stats();
`ifdef MEM_DMA_FILL_EN
    exp_rd = 0;
    for (int n = 0; n < 3; n++) begin exp_a.push_back(AW'(32'hC00000 + n)); exp_d.push_back(32'hDEADBEEF); end
`else
    exp_rd = 3;
    for (int n = 0; n < 3; n++) begin exp_a.push_back(AW'(32'hC00000 + n)); exp_d.push_back(32'hA0 + n); end
`endif
    pulse_go(27'h800000, 27'hC00000, 16'd3, 32'hDEADBEEF, 1'b1);
    wait_done(200, ok);
    checks++; if (!ok || words_done !== 16'd3) begin failures++; $display("FAIL fill_done got ok=%0d wd=%0d want 1/3", ok, words_done); end
    checks++; if (rd_cnt != exp_rd) begin failures++; $display("FAIL fill_reads got %0d want %0d", rd_cnt, exp_rd); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); ed = exp_d.pop_front(); checks++;
      if (act_a.size() == 0) begin failures++; $display("FAIL fill_write missing want %h<=%h", ea, ed); end
      else begin
        aa = act_a.pop_front(); ad = act_d.pop_front();
        if (aa !== ea || ad !== ed) begin failures++; $display("FAIL fill_write got %h<=%h want %h<=%h", aa, ad, ea, ed); end
      end
    end
  endtask

  task automatic test_reset_midjob();
    bit seen;
    clr_stats(); lat = 8; seen = 1'b0;
    pulse_go(27'h800000, 27'h300, 16'd2, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (mem_busy) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL midjob_no_access got busy=0 want 1"); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({mem_start, mem_we, dma_busy} !== 3'b000) begin failures++; $display("FAIL midjob_async_drop got %b%b%b want 000", mem_start, mem_we, dma_busy); end
    @(negedge clk); reset = 1'b1;
    rises = 0; done_cnt = 0;
    checks++; if (mem_busy !== 1'b1) begin failures++; $display("FAIL midjob_busy_held got %b want 1", mem_busy); end
    pulse_go(27'h800000, 27'h310, 16'd1, 32'h0, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (rises != 0 || done_cnt != 0) begin failures++; $display("FAIL midjob_go_refused got starts=%0d dones=%0d want 0/0", rises, done_cnt); end
    lat = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_copy();
    test_len0();
    test_timeout();
    test_ignore();
    test_wrap();
    test_fill();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
